// File: rtl/instr_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : instr_bus_mux
//  Purpose  : Instruction-fetch interconnect. Decodes each core fetch address
//             to boot ROM (device 0), instruction SRAM (device 1) or an
//             unmapped region that gets a local error response. Outstanding
//             requests are only ever in flight to a single target, so
//             responses return to the core in order without reordering.
//  Ports    : clk, rst (synchronous, active-low)
//             host_*  : core-side req/gnt/rvalid fetch port
//             dev0_*  : boot ROM port
//             dev1_*  : instruction SRAM port
//             bus_fault_o : sticky flag, set by a device response that has
//                           no matching outstanding request
//  Revision : 1.0 - initial release
// ============================================================================
module instr_bus_mux #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_0000,
    parameter logic [31:0] DEV0_MASK = 32'hFFFF_FF00,
    parameter logic [31:0] DEV1_BASE = 32'h0001_0000,
    parameter logic [31:0] DEV1_MASK = 32'hFFFF_0000,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        host_req_i,
    output logic        host_gnt_o,
    input  logic [31:0] host_addr_i,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic [6:0]  host_rdata_intg_o,
    output logic        host_err_o,

    output logic        dev0_req_o,
    input  logic        dev0_gnt_i,
    output logic [31:0] dev0_addr_o,
    input  logic        dev0_rvalid_i,
    input  logic [31:0] dev0_rdata_i,
    input  logic        dev0_err_i,

    output logic        dev1_req_o,
    input  logic        dev1_gnt_i,
    output logic [31:0] dev1_addr_o,
    input  logic        dev1_rvalid_i,
    input  logic [31:0] dev1_rdata_i,
    input  logic        dev1_err_i,

    output logic        bus_fault_o
);

    localparam logic [1:0] c_TGT_DEV0 = 2'd0;
    localparam logic [1:0] c_TGT_DEV1 = 2'd1;
    localparam logic [1:0] c_TGT_ERR  = 2'd2;
    localparam logic [1:0] c_MAX_CNT  = MAX_OUTST[1:0];

    logic [1:0] outst_cnt_q, outst_cnt_d;
    logic [1:0] cur_tgt_q,   cur_tgt_d;
    logic       err_rsp_q,   err_rsp_d;
    logic       bus_fault_q, bus_fault_d;

    logic [1:0] w_tgt;
    logic       w_ok;
    logic       w_req_ok;
    logic       w_gnt;
    logic       w_fwd0;
    logic       w_fwd1;
    logic       w_rsp;
    logic       w_stray;

    // Address decode; device 0 wins when the two windows overlap.
    always_comb begin
        if ((host_addr_i & DEV0_MASK) == DEV0_BASE) begin
            w_tgt = c_TGT_DEV0;
        end else if ((host_addr_i & DEV1_MASK) == DEV1_BASE) begin
            w_tgt = c_TGT_DEV1;
        end else begin
            w_tgt = c_TGT_ERR;
        end
    end

    // Acceptance looks only at registered state. Restricting new requests to
    // the target already in flight is what keeps responses in order; a
    // target switch waits until the counter has actually reached zero.
    assign w_ok     = (outst_cnt_q < c_MAX_CNT) &&
                      ((outst_cnt_q == 2'd0) || (w_tgt == cur_tgt_q));
    assign w_req_ok = rst && host_req_i && w_ok;

    assign dev0_req_o  = w_req_ok && (w_tgt == c_TGT_DEV0);
    assign dev1_req_o  = w_req_ok && (w_tgt == c_TGT_DEV1);
    assign dev0_addr_o = host_addr_i;
    assign dev1_addr_o = host_addr_i;

    always_comb begin
        w_gnt = 1'b0;
        unique case (w_tgt)
            c_TGT_DEV0: w_gnt = dev0_req_o && dev0_gnt_i;
            c_TGT_DEV1: w_gnt = dev1_req_o && dev1_gnt_i;
            default:    w_gnt = w_req_ok;
        endcase
    end
    assign host_gnt_o = w_gnt;

    // A device response is forwarded only when that device owns the
    // outstanding requests; anything else is a stray and gets dropped.
    assign w_fwd0  = dev0_rvalid_i && (outst_cnt_q != 2'd0) && (cur_tgt_q == c_TGT_DEV0);
    assign w_fwd1  = dev1_rvalid_i && (outst_cnt_q != 2'd0) && (cur_tgt_q == c_TGT_DEV1);
    assign w_stray = (dev0_rvalid_i && !w_fwd0) || (dev1_rvalid_i && !w_fwd1);
    assign w_rsp   = rst && (w_fwd0 || w_fwd1 || err_rsp_q);

    always_comb begin
        host_rvalid_o = 1'b0;
        host_rdata_o  = 32'h0;
        host_err_o    = 1'b0;
        if (rst) begin
            if (w_fwd0) begin
                host_rvalid_o = 1'b1;
                host_rdata_o  = dev0_rdata_i;
                host_err_o    = dev0_err_i;
            end else if (w_fwd1) begin
                host_rvalid_o = 1'b1;
                host_rdata_o  = dev1_rdata_i;
                host_err_o    = dev1_err_i;
            end else if (err_rsp_q) begin
                host_rvalid_o = 1'b1;
                host_err_o    = 1'b1;
            end
        end
    end

    assign host_rdata_intg_o = 7'b0;
    assign bus_fault_o       = rst && bus_fault_q;

    always_comb begin
        outst_cnt_d = outst_cnt_q;
        unique case ({w_gnt, w_rsp})
            2'b10:   outst_cnt_d = outst_cnt_q + 2'd1;
            2'b01:   outst_cnt_d = outst_cnt_q - 2'd1;
            default: outst_cnt_d = outst_cnt_q;
        endcase
        cur_tgt_d   = w_gnt ? w_tgt : cur_tgt_q;
        // The local error response always lands the cycle after its grant.
        err_rsp_d   = w_gnt && (w_tgt == c_TGT_ERR);
        bus_fault_d = bus_fault_q || w_stray;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outst_cnt_q <= 2'd0;
            cur_tgt_q   <= c_TGT_DEV0;
            err_rsp_q   <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            outst_cnt_q <= outst_cnt_d;
            cur_tgt_q   <= cur_tgt_d;
            err_rsp_q   <= err_rsp_d;
            bus_fault_q <= bus_fault_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_bus_mux
//  Purpose  : Self-checking bench for instr_bus_mux. Bench-side ROM/SRAM
//             models answer granted requests after a programmable latency;
//             a transaction-level model (queue of outstanding fetches) gives
//             the expected outputs for every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_bus_mux;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_req_i = 1'b0;
    logic        host_gnt_o;
    logic [31:0] host_addr_i = 32'h0;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic [6:0]  host_rdata_intg_o;
    logic        host_err_o;
    logic        dev0_req_o, dev1_req_o;
    logic        dev0_gnt_i = 1'b0, dev1_gnt_i = 1'b0;
    logic [31:0] dev0_addr_o, dev1_addr_o;
    logic        dev0_rvalid_i = 1'b0, dev1_rvalid_i = 1'b0;
    logic [31:0] dev0_rdata_i = 32'h0, dev1_rdata_i = 32'h0;
    logic        dev0_err_i = 1'b0, dev1_err_i = 1'b0;
    logic        bus_fault_o;

    instr_bus_mux #(
        .DEV0_BASE (32'h0000_0000),
        .DEV0_MASK (32'hFFFF_FF00),
        .DEV1_BASE (32'h0001_0000),
        .DEV1_MASK (32'hFFFF_0000),
        .MAX_OUTST (MAXO)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .host_req_i        (host_req_i),
        .host_gnt_o        (host_gnt_o),
        .host_addr_i       (host_addr_i),
        .host_rvalid_o     (host_rvalid_o),
        .host_rdata_o      (host_rdata_o),
        .host_rdata_intg_o (host_rdata_intg_o),
        .host_err_o        (host_err_o),
        .dev0_req_o        (dev0_req_o),
        .dev0_gnt_i        (dev0_gnt_i),
        .dev0_addr_o       (dev0_addr_o),
        .dev0_rvalid_i     (dev0_rvalid_i),
        .dev0_rdata_i      (dev0_rdata_i),
        .dev0_err_i        (dev0_err_i),
        .dev1_req_o        (dev1_req_o),
        .dev1_gnt_i        (dev1_gnt_i),
        .dev1_addr_o       (dev1_addr_o),
        .dev1_rvalid_i     (dev1_rvalid_i),
        .dev1_rdata_i      (dev1_rdata_i),
        .dev1_err_i        (dev1_err_i),
        .bus_fault_o       (bus_fault_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Response content of the bench's devices for a given fetch address.
    function automatic logic [32:0] dev_rsp(input int dev, input logic [31:0] a);
        logic [31:0] d;
        logic        e;
        d = (a * 32'h9E37_79B1) ^ ((dev == 1) ? 32'h5A5A_0000 : 32'h0000_A5A5);
        if (dev == 0 && a == 32'h0000_0080) d = 32'h0000_15B7;
        e = (dev == 1) && (a[4:2] == 3'b111);
        return {e, d};
    endfunction

    // Target: 0 = ROM, 1 = SRAM, 2 = unmapped.
    function automatic int decode(input logic [31:0] a);
        if ((a & 32'hFFFF_FF00) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_0000) == 32'h0001_0000) return 1;
        return 2;
    endfunction

    // ---------------- transaction-level reference model --------------------
    typedef struct {
        int          tgt;
        logic [31:0] addr;
    } fetch_t;

    fetch_t mq[$];
    logic   m_fault   = 1'b0;
    logic   m_fault_n = 1'b0;
    logic   m_clear   = 1'b1;
    logic   m_pop     = 1'b0;
    logic   m_push    = 1'b0;
    fetch_t m_item;

    initial begin : p_compare
        int          t;
        logic        ok, e_req0, e_req1, e_gnt, e_rv, e_err, stray;
        logic [31:0] e_rd;
        logic [32:0] r;
        forever begin
            @(negedge clk);
            e_req0 = 0; e_req1 = 0; e_gnt = 0; e_rv = 0; e_err = 0; e_rd = 0;
            m_pop = 0; m_push = 0;
            if (!rst) begin
                m_clear   = 1;
                m_fault_n = 0;
            end else begin
                m_clear = 0;
                t  = decode(host_addr_i);
                ok = (mq.size() < MAXO) && (mq.size() == 0 || mq[mq.size()-1].tgt == t);
                if (host_req_i && ok) begin
                    e_req0 = (t == 0);
                    e_req1 = (t == 1);
                    e_gnt  = (t == 0) ? dev0_gnt_i : (t == 1) ? dev1_gnt_i : 1'b1;
                end
                if (mq.size() > 0) begin
                    if (mq[0].tgt == 2) begin
                        e_rv = 1; e_err = 1;
                    end else if ((mq[0].tgt == 0 && dev0_rvalid_i) ||
                                 (mq[0].tgt == 1 && dev1_rvalid_i)) begin
                        r = dev_rsp(mq[0].tgt, mq[0].addr);
                        e_rv = 1; e_err = r[32]; e_rd = r[31:0];
                    end
                end
                stray = (dev0_rvalid_i && !(mq.size() > 0 && mq[0].tgt == 0)) ||
                        (dev1_rvalid_i && !(mq.size() > 0 && mq[0].tgt == 1));
                m_fault_n = m_fault | stray;
                m_pop     = e_rv;
                m_push    = e_gnt;
                m_item.tgt  = t;
                m_item.addr = host_addr_i;
            end
            chk("dev0_req", {63'h0, dev0_req_o}, {63'h0, e_req0});
            chk("dev1_req", {63'h0, dev1_req_o}, {63'h0, e_req1});
            chk("host_gnt", {63'h0, host_gnt_o}, {63'h0, e_gnt});
            chk("host_rvalid", {63'h0, host_rvalid_o}, {63'h0, e_rv});
            chk("host_rdata", {32'h0, host_rdata_o}, {32'h0, e_rd});
            chk("host_err", {63'h0, host_err_o}, {63'h0, e_err});
            chk("rdata_intg", {57'h0, host_rdata_intg_o}, 64'h0);
            chk("bus_fault", {63'h0, bus_fault_o}, {63'h0, m_fault & rst});
            chk("dev_addr", {dev0_addr_o, dev1_addr_o}, {host_addr_i, host_addr_i});
        end
    end

    initial begin : p_model_commit
        forever begin
            @(posedge clk);
            if (m_clear) begin
                mq.delete();
            end else begin
                if (m_pop && mq.size() > 0) void'(mq.pop_front());
                if (m_push) mq.push_back(m_item);
            end
            m_fault = m_fault_n;
        end
    end

    // ---------------- bench-side device models ------------------------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } drsp_t;

    drsp_t dq0[$], dq1[$];
    int    last_due0 = 0, last_due1 = 0;
    int    cyc = 0;
    int    lat0 = 1, lat1 = 1;       // 0 selects a random latency 1..4
    logic  gnt_rand = 1'b0;
    logic  spur1 = 1'b0;
    logic  g_seen = 1'b0;

    task automatic drive_devices();
        drsp_t d;
        dev0_rvalid_i = 0; dev0_rdata_i = 0; dev0_err_i = 0;
        dev1_rvalid_i = 0; dev1_rdata_i = 0; dev1_err_i = 0;
        if (dq0.size() > 0 && dq0[0].due <= cyc) begin
            d = dq0.pop_front();
            dev0_rvalid_i = 1; dev0_rdata_i = d.data; dev0_err_i = d.err;
        end
        if (dq1.size() > 0 && dq1[0].due <= cyc) begin
            d = dq1.pop_front();
            dev1_rvalid_i = 1; dev1_rdata_i = d.data; dev1_err_i = d.err;
        end else if (spur1) begin
            dev1_rvalid_i = 1; dev1_rdata_i = 32'hDEAD_BEEF; dev1_err_i = 0;
        end
        dev0_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        dev1_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic cyc_begin(input logic r, input logic [31:0] a, input logic rn);
        @(posedge clk);
        #1;
        cyc++;
        rst = rn;
        if (!rn) begin
            dq0.delete();
            dq1.delete();
        end
        host_req_i  = r;
        host_addr_i = a;
        drive_devices();
        #4;
    endtask

    task automatic cyc_end();
        drsp_t       d;
        int          l;
        logic [32:0] r;
        #3;
        g_seen = host_gnt_o;
        if (rst && dev0_req_o && dev0_gnt_i) begin
            l = (lat0 != 0) ? lat0 : $urandom_range(1, 4);
            d.due = (cyc + l > last_due0) ? cyc + l : last_due0 + 1;
            last_due0 = d.due;
            r = dev_rsp(0, dev0_addr_o);
            d.data = r[31:0]; d.err = r[32];
            dq0.push_back(d);
        end
        if (rst && dev1_req_o && dev1_gnt_i) begin
            l = (lat1 != 0) ? lat1 : $urandom_range(1, 4);
            d.due = (cyc + l > last_due1) ? cyc + l : last_due1 + 1;
            last_due1 = d.due;
            r = dev_rsp(1, dev1_addr_o);
            d.data = r[31:0]; d.err = r[32];
            dq1.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin(1'b0, 32'h0, 1'b1);
            cyc_end();
        end
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin : p_stim
        int          gcount;
        logic        hreq;
        logic [31:0] haddr;
        int          kind;

        // Reset
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1, 32'h80, 1'b0);
            chk("rst_dev0_req", {63'h0, dev0_req_o}, 64'h0);
            chk("rst_gnt", {63'h0, host_gnt_o}, 64'h0);
            cyc_end();
        end

        // Boot ROM fetch
        cyc_begin(1'b1, 32'h80, 1'b1);
        chk("rom_req", {63'h0, dev0_req_o}, 64'h1);
        chk("rom_gnt", {63'h0, host_gnt_o}, 64'h1);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        chk("rom_rvalid", {63'h0, host_rvalid_o}, 64'h1);
        chk("rom_rdata", {32'h0, host_rdata_o}, 64'h0000_15B7);
        chk("rom_err", {63'h0, host_err_o}, 64'h0);
        cyc_end();

        // Streaming: eight back-to-back ROM fetches
        gcount = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin(1'b1, 32'h80 + 32'(4 * i), 1'b1);
            cyc_end();
            if (g_seen) gcount++;
        end
        idle(4);
        chk("stream_grants", 64'(gcount), 64'd8);

        // Unmapped address
        cyc_begin(1'b1, 32'h0000_1000, 1'b1);
        chk("err_gnt", {63'h0, host_gnt_o}, 64'h1);
        chk("err_no_devreq", {62'h0, dev0_req_o, dev1_req_o}, 64'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        chk("err_rsp", {62'h0, host_rvalid_o, host_err_o}, 64'h3);
        chk("err_rdata", {32'h0, host_rdata_o}, 64'h0);
        cyc_end();
        idle(2);

        // Target switch ROM -> SRAM
        cyc_begin(1'b1, 32'h9C, 1'b1);
        chk("sw_rom_gnt", {63'h0, host_gnt_o}, 64'h1);
        cyc_end();
        lat1 = 3;
        cyc_begin(1'b1, 32'h0001_0000, 1'b1);
        chk("sw_stall", {62'h0, dev1_req_o, host_gnt_o}, 64'h0);
        chk("sw_rom_rsp", {63'h0, host_rvalid_o}, 64'h1);
        cyc_end();
        cyc_begin(1'b1, 32'h0001_0000, 1'b1);
        chk("sw_sram_req", {62'h0, dev1_req_o, host_gnt_o}, 64'h3);
        cyc_end();
        idle(6);

        // Saturation with SRAM latency 4
        lat1 = 4;
        cyc_begin(1'b1, 32'h0001_0004, 1'b1);
        chk("sat_gnt0", {63'h0, host_gnt_o}, 64'h1);
        cyc_end();
        cyc_begin(1'b1, 32'h0001_0008, 1'b1);
        chk("sat_gnt1", {63'h0, host_gnt_o}, 64'h1);
        cyc_end();
        for (int k = 2; k <= 5; k++) begin
            cyc_begin(1'b1, 32'h0001_000C, 1'b1);
            chk("sat_gnt_hold", {63'h0, host_gnt_o}, (k == 5) ? 64'h1 : 64'h0);
            if (k == 4) chk("sat_rsp_full", {63'h0, host_rvalid_o}, 64'h1);
            cyc_end();
        end
        idle(8);

        // Stray SRAM response with nothing outstanding
        spur1 = 1'b1;
        cyc_begin(1'b0, 32'h0, 1'b1);
        spur1 = 1'b0;
        chk("stray_dropped", {63'h0, host_rvalid_o}, 64'h0);
        chk("stray_fault_lag", {63'h0, bus_fault_o}, 64'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        chk("stray_fault", {63'h0, bus_fault_o}, 64'h1);
        cyc_end();

        // Reset in the middle of a ROM burst
        lat0 = 2;
        cyc_begin(1'b1, 32'h80, 1'b1); cyc_end();
        cyc_begin(1'b1, 32'h84, 1'b1); cyc_end();
        cyc_begin(1'b1, 32'h88, 1'b0);
        chk("midrst_outs", {58'h0, dev0_req_o, dev1_req_o, host_gnt_o, host_rvalid_o,
                            host_err_o, bus_fault_o}, 64'h0);
        chk("midrst_rdata", {32'h0, host_rdata_o}, 64'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        chk("postrst_clear", {62'h0, bus_fault_o, host_rvalid_o}, 64'h0);
        cyc_end();

        // Randomized traffic
        gnt_rand = 1'b1;
        lat0 = 0;
        lat1 = 0;
        hreq  = 1'b0;
        haddr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!hreq && $urandom_range(0, 3) != 0) begin
                hreq = 1'b1;
                kind = $urandom_range(0, 4);
                if (kind <= 1)      haddr = {24'h0, 6'($urandom), 2'b00};
                else if (kind <= 3) haddr = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
                else                haddr = 32'h0000_1000 + 32'($urandom_range(0, 63) * 4);
            end
            cyc_begin(hreq, haddr, 1'b1);
            cyc_end();
            if (g_seen) hreq = 1'b0;
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_bus_mux.md
# instr_bus_mux

Instruction-fetch interconnect between the RISC-V core's instruction port and the fetch-side devices: boot ROM (device 0) and instruction SRAM (device 1). Decodes each request address, forwards the request to the one matching device, and tracks outstanding transactions so responses return to the core in order. Requests to unmapped addresses get a locally generated error response. Every port uses the core's req/gnt/rvalid protocol.

## Interface
- DEV0_BASE, 32'h0000_0000, device 0 (boot ROM) base address
- DEV0_MASK, 32'hFFFF_FF00, device 0 match mask: hit when (addr & MASK) == BASE
- DEV1_BASE, 32'h0001_0000, device 1 (SRAM) base address
- DEV1_MASK, 32'hFFFF_0000, device 1 match mask
- MAX_OUTST, 2, maximum outstanding granted-but-unanswered requests (1..3)

Reset and clock: rst, synchronous, active-low; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- host_req_i  in  1  core fetch request
- host_gnt_o  out  1  grant to core
- host_addr_i  in  32  fetch address
- host_rvalid_o  out  1  response valid to core
- host_rdata_o  out  32  response data
- host_rdata_intg_o  out  7  response integrity; always 7'b0
- host_err_o  out  1  response error
- devN_req_o  out  1  request to device N (N=0,1)
- devN_gnt_i  in  1  grant from device N
- devN_addr_o  out  32  address to device N (host_addr_i passthrough)
- devN_rvalid_i  in  1  response valid from device N
- devN_rdata_i  in  32  response data from device N
- devN_err_i  in  1  response error from device N
- bus_fault_o  out  1  sticky: unexpected device rvalid seen

## Operation
- Decode (combinational): tgt = 0 if dev0 hit, else 1 if dev1 hit, else 2 (ERR). Dev0 wins on overlap.
- State: outst_cnt (0..MAX_OUTST), cur_tgt (2 bits), err_rsp_q (1 bit), bus_fault_q.
- Accept condition: ok = (outst_cnt < MAX_OUTST) && (outst_cnt == 0 || tgt == cur_tgt). The same-target rule guarantees in-order responses. Evaluate ok on registered state only; never use same-cycle rvalid.
- devN_req_o = host_req_i && ok && tgt==N. host_gnt_o = devN_gnt_i of the selected device, or host_req_i && ok when tgt==ERR.
- On grant: cur_tgt <= tgt. If tgt==ERR, err_rsp_q <= 1.
- Response selection by cur_tgt:
  - Device: host_rvalid_o/rdata/err = devN signals.
  - ERR: host_rvalid_o = err_rsp_q, host_rdata_o = 0, host_err_o = 1.
- Each host_rvalid_o decrements outst_cnt. Grant and response in the same cycle leave outst_cnt unchanged.
- Device rvalid while outst_cnt==0, or from a device ≠ cur_tgt: the response is dropped (not forwarded) and bus_fault_q <= 1. bus_fault_q is cleared only by reset.
- When host_rvalid_o=0, host_rdata_o=0 and host_err_o=0.

## Timing
- Request path is fully combinational: host_req_i -> devN_req_o -> devN_gnt_i -> host_gnt_o in the same cycle.
- Response path is combinational passthrough, zero added latency. Boot ROM example: gnt in cycle T, host_rvalid_o in T+1.
- ERR target: granted immediately when ok; host_rvalid_o with err=1 exactly one cycle after grant. Back-to-back ERR requests give one response per cycle.
- Target switch stalls while outst_cnt>0, including the cycle in which the last response arrives. First grant to the new target is the following cycle (one bubble).
- outst_cnt==MAX_OUTST: host_gnt_o=0 even if a response arrives that cycle.
- While rst==0: all devN_req_o=0, host_gnt_o=0, host_rvalid_o=0, host_rdata_o=0, host_err_o=0, outst_cnt=0, cur_tgt=0, err_rsp_q=0, bus_fault_o=0.
- Responses pending at reset are discarded. Device responses arriving in the first cycles after reset release set bus_fault_o; this is accepted behaviour.

## Test plan
- Boot ROM fetch: req addr 0x80 with a ROM model returning 0x000015B7. Required: dev0_req_o=1, gnt same cycle, host_rvalid_o next cycle, rdata 0x000015B7, err=0.
- Streaming: 8 back-to-back ROM fetches 0x80–0x9C. Required: one grant per cycle, outst_cnt never exceeds 2, rdata in address order.
- Unmapped: req addr 0x0000_1000. Required: gnt same cycle, rvalid+err=1, rdata=0 next cycle, no devN_req_o.
- Target switch: ROM fetch at 0x9C, then SRAM fetch at 0x10000 held with SRAM latency 3. Required: SRAM request not forwarded until the ROM response completes plus one cycle; responses in order.
- Saturation with MAX_OUTST=2: SRAM delays rvalid 4 cycles, 3 requests issued. Required: third gnt withheld until outst_cnt drops to 1.
- Faults: inject dev1_rvalid_i with zero outstanding → bus_fault_o=1, nothing forwarded. Then assert rst=0 mid-burst → all outputs 0 next cycle and bus_fault_o cleared.
